// File: rtl/mod_engine_scheduler.sv
// Round-robin arbiter sharing one bit-serial modulo engine across requesters.
// Optional engine watchdog with abort: define SCHED_TIMEOUT_EN.
module mod_engine_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 9,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     eng_start,
  output logic                     eng_abort,
  output logic [WIDTH-1:0]         eng_dividend,
  output logic [WIDTH-1:0]         eng_divisor,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_remainder,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_divisible,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [ID_W-1:0] PTR_RST =
    ID_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;
  logic             tmo;

  // First valid requester after the last winner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign sel_dvd = req_dividend[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_dvs = req_divisor[int'(gnt_id)*WIDTH +: WIDTH];

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last allowed WAIT cycle; a same-cycle done wins.
  assign tmo = (state_q == WAIT) && !eng_done &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign eng_abort = tmo;
`else
  assign tmo       = (TIMEOUT_CYCLES < 0);
  assign eng_abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    err_d     = err_q;
    req_ready = '0;
    eng_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready = NUM_REQ'(1) << gnt_id;
          ptr_d     = gnt_id;
          id_d      = gnt_id;
          dvd_d     = sel_dvd;
          dvs_d     = sel_dvs;
          if (sel_dvs == '0) begin
            rem_d   = sel_dvd;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            rem_d   = '0;
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rem_d   = eng_remainder;
          state_d = RESP;
        end else if (tmo) begin
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = id_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;
  assign rsp_divisible = rsp_valid && !err_q &&
                         (rem_q == '0);
  assign eng_dividend  = dvd_q;
  assign eng_divisor   = dvs_q;

endmodule

// File: tb/tb_mod_engine_scheduler.sv
// Directed bench for mod_engine_scheduler with a cycle-exact engine model.
// Watchdog section exercised when SCHED_TIMEOUT_EN is defined.
module tb_mod_engine_scheduler;

  localparam int N  = 4;
  localparam int W  = 9;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic           eng_start;
  logic           eng_abort;
  logic [W-1:0]   eng_dividend;
  logic [W-1:0]   eng_divisor;
  logic           eng_done;
  logic [W-1:0]   eng_remainder;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_divisible;
  logic           rsp_err;
  logic           busy;

  always #5 clk = ~clk;

  mod_engine_scheduler #(
    .NUM_REQ(N),
    .WIDTH(W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .eng_start(eng_start),
    .eng_abort(eng_abort),
    .eng_dividend(eng_dividend),
    .eng_divisor(eng_divisor),
    .eng_done(eng_done),
    .eng_remainder(eng_remainder),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_remainder(rsp_remainder),
    .rsp_divisible(rsp_divisible),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct {
    int id;
    int dvd;
    int dvs;
    int lat;
    int exp_rem;
    bit exp_div;
    bit exp_err;
  } vec_t;

  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   order[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int id,
                         input int dvd,
                         input int dvs);
    req_valid[id] = 1'b1;
    req_dividend[id*W +: W] = W'(dvd);
    req_divisor[id*W +: W]  = W'(dvs);
  endtask

  task automatic run_job(input vec_t v);
    set_req(v.id, v.dvd, v.dvs);
    settle();
    chk("grant", req_ready, 1 << v.id);
    nxt();
    req_valid = '0;
    settle();
    chk("ready_drop", req_ready, 0);
    if (v.dvs != 0) begin
      chk("start", eng_start, 1);
      chk("eng_dvd", eng_dividend, v.dvd);
      chk("eng_dvs", eng_divisor, v.dvs);
      for (int c = 1; c < v.lat; c++) begin
        nxt();
        settle();
        chk("wait_quiet", {eng_start, rsp_valid}, 0);
      end
      nxt();
      eng_done      = 1'b1;
      eng_remainder = W'(v.dvd % v.dvs);
      settle();
      chk("pre_rsp", rsp_valid, 0);
      chk("eng_hold", eng_dividend, v.dvd);
      nxt();
      eng_done      = 1'b0;
      eng_remainder = '0;
      settle();
    end else begin
      chk("no_start", eng_start, 0);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_rem", rsp_remainder, v.exp_rem);
    chk("rsp_div", rsp_divisible, v.exp_div);
    chk("rsp_err", rsp_err, v.exp_err);
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    settle();
    chk("back_idle", {rsp_valid, busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 503, 14, 40, 13, 1'b0, 1'b0};
    vecs[1] = '{2, 504, 14, 10, 0, 1'b1, 1'b0};
    vecs[2] = '{3, 77, 0, 0, 77, 1'b0, 1'b1};
    vecs[3] = '{0, 5, 9, 3, 5, 1'b0, 1'b0};
    vecs[4] = '{2, 511, 511, 1, 0, 1'b1, 1'b0};
    vecs[5] = '{0, 0, 0, 0, 0, 1'b0, 1'b1};
    order   = '{0, 1, 2, 3, 0};

    rst_n         = 1'b0;
    req_valid     = '0;
    req_dividend  = '0;
    req_divisor   = '0;
    eng_done      = 1'b0;
    eng_remainder = '0;
    rsp_ready     = 1'b0;
    nxt();
    nxt();
    settle();
    chk("rst_ready", req_ready, 0);
    chk("rst_ctl", {eng_start, eng_abort, rsp_valid, busy}, 0);
    chk("rst_rsp", {rsp_id, rsp_remainder,
                    rsp_divisible, rsp_err}, 0);
    chk("rst_eng", {eng_dividend, eng_divisor}, 0);
    rst_n = 1'b1;
    nxt();

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i]);
    end

    // Back-pressured response, queued request, stray done.
    nxt();
    set_req(3, 200, 9);
    settle();
    chk("bp_grant", req_ready, 4'b1000);
    nxt();
    req_valid = '0;
    settle();
    chk("bp_start", eng_start, 1);
    nxt();
    nxt();
    eng_done      = 1'b1;
    eng_remainder = 9'd2;
    settle();
    nxt();
    eng_done      = 1'b0;
    eng_remainder = '0;
    set_req(0, 55, 0);
    settle();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        eng_done      = 1'b1;
        eng_remainder = 9'd77;
      end else begin
        eng_done = 1'b0;
      end
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rem", rsp_remainder, 2);
      chk("bp_id", rsp_id, 3);
      chk("bp_no_grant", req_ready, 0);
      nxt();
      settle();
    end
    eng_done  = 1'b0;
    rsp_ready = 1'b1;
    settle();
    chk("hs_no_grant", req_ready, 0);
    chk("hs_rem", rsp_remainder, 2);
    nxt();
    rsp_ready = 1'b0;
    settle();
    chk("after_hs_grant", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    settle();
    chk("z_valid", rsp_valid, 1);
    chk("z_err_rem", {rsp_err, rsp_remainder}, {1'b1, 9'd55});
    rsp_ready = 1'b1;
    nxt();
    rsp_ready     = 1'b0;
    eng_done      = 1'b1;
    eng_remainder = 9'd5;
    settle();
    nxt();
    eng_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stray_done", {rsp_valid, busy}, 0);
      nxt();
    end

    // Silent engine: watchdog or indefinite wait, then reset.
    set_req(2, 100, 7);
    settle();
    chk("silent_grant", req_ready, 4'b0100);
    nxt();
    req_valid = '0;
    settle();
    chk("silent_start", eng_start, 1);
`ifdef SCHED_TIMEOUT_EN
    for (int w = 1; w <= 16; w++) begin
      nxt();
      settle();
      chk("abort", eng_abort, (w == 16) ? 1 : 0);
      chk("tmo_wait", rsp_valid, 0);
    end
    nxt();
    eng_done      = 1'b1;
    eng_remainder = 9'd2;
    settle();
    chk("tmo_rsp", {rsp_valid, rsp_err, rsp_divisible}, 3'b110);
    chk("tmo_rem", rsp_remainder, 0);
    chk("tmo_abort_low", eng_abort, 0);
    nxt();
    eng_done = 1'b0;
    settle();
    chk("late_done", rsp_remainder, 0);
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    settle();
    chk("tmo_idle", busy, 0);
    set_req(1, 300, 11);
    settle();
    chk("re_grant", req_ready, 4'b0010);
    nxt();
    req_valid = '0;
    nxt();
    settle();
`else
    for (int w = 1; w <= 20; w++) begin
      nxt();
      settle();
      chk("no_abort", eng_abort, 0);
      chk("still_wait", {busy, rsp_valid}, 2'b10);
    end
`endif
    chk("in_wait", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {busy, rsp_valid, eng_start, eng_abort}, 0);
    chk("arst_rsp", {rsp_id, rsp_remainder, rsp_err}, 0);
    chk("arst_eng", eng_dividend, 0);
    nxt();
    settle();
    chk("rst_hold", busy, 0);
    rst_n = 1'b1;
    nxt();

    // All requesters held valid: fair rotation from 0.
    for (int i = 0; i < N; i++) begin
      set_req(i, 100 + i, 10);
    end
    settle();
    for (int j = 0; j < 5; j++) begin
      chk("rr_grant", req_ready, 1 << order[j]);
      nxt();
      settle();
      chk("rr_ready_low", req_ready, 0);
      chk("rr_start", eng_start, 1);
      chk("rr_dvd", eng_dividend, 100 + order[j]);
      nxt();
      settle();
      chk("rr_wait_ready", req_ready, 0);
      nxt();
      eng_done      = 1'b1;
      eng_remainder = W'((100 + order[j]) % 10);
      settle();
      nxt();
      eng_done      = 1'b0;
      eng_remainder = '0;
      settle();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, order[j]);
      chk("rr_rem", rsp_remainder, order[j]);
      chk("rr_resp_ready", req_ready, 0);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;
      settle();
    end
    req_valid = '0;
    settle();
    chk("drop_ready", req_ready, 0);
    nxt();
    settle();
    chk("not_sticky", {busy, rsp_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_engine_scheduler.md
Name: mod_engine_scheduler

Overview:
- Round-robin scheduler that shares one bit-serial modulo engine between NUM_REQ requesters.
- The engine computes dividend mod divisor and is a sibling of the divisibility checker.
- Accepts one job at a time from a requester and launches the engine with a start pulse.
- Waits for the engine's done pulse, then returns the remainder, a divisible flag and the requester id on a valid/ready response port.
- Handles a zero divisor locally; the engine never sees one, because it would never terminate.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 9, operand and remainder width in bits.
- ID_W, $clog2(NUM_REQ), requester id width (derived; do not override).
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles (used only with SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_dividend  in  NUM_REQ*WIDTH  packed dividends; requester i occupies [i*WIDTH +: WIDTH].
- req_divisor  in  NUM_REQ*WIDTH  packed divisors, same packing.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_abort  out  1  one-cycle abort pulse to the engine.
- eng_dividend  out  WIDTH  operand to the engine.
- eng_divisor  out  WIDTH  operand to the engine.
- eng_done  in  1  one-cycle completion pulse from the engine.
- eng_remainder  in  WIDTH  engine result, valid with eng_done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  id of the requester that owns the response.
- rsp_remainder  out  WIDTH  remainder.
- rsp_divisible  out  1  1 when remainder == 0 and err == 0.
- rsp_err  out  1  divisor-zero or timeout.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Clock is clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-job: the scheduler returns to IDLE immediately; the engine is reset by the same rst_n.
- States:
  - IDLE: if any req_valid, grant the first set bit searching from pointer+1, wrapping modulo NUM_REQ.
    - req_ready = grant one-hot, combinational, for that one cycle only; req_ready is 0 in all other states.
    - Capture that requester's operands and id.
    - Next state is RESP if divisor == 0, else ISSUE.
    - Pointer is updated to the granted id at grant.
  - ISSUE: eng_start = 1 for exactly one cycle; next state WAIT.
  - WAIT: on eng_done, capture eng_remainder and go to RESP. eng_done seen in any other state is ignored.
  - RESP: rsp_valid = 1 and rsp_* held stable until rsp_ready is sampled high; then go to IDLE.
- eng_dividend and eng_divisor are driven from the captured registers and held stable from ISSUE until the WAIT exit.
- Divisor zero: rsp_err = 1, rsp_remainder = dividend, rsp_divisible = 0; rsp_valid rises 1 cycle after the grant.
- Dividend < divisor is not special-cased; it is passed to the engine.
- Latency:
  - eng_start is asserted the cycle after the grant.
  - rsp_valid is asserted the cycle after eng_done.
  - Minimum overhead is 4 cycles per job plus engine time.
- A request is not sticky: a requester that drops req_valid before being granted loses nothing and gets no response.
- A rsp_ready handshake and a pending req_valid never overlap. The new grant happens in IDLE, the cycle after the handshake.
- A requester with req_valid held high is re-granted only after every other valid requester has been served (fairness).

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without eng_done: pulse eng_abort for one cycle and go to RESP with rsp_err = 1, rsp_remainder = 0.
  - A late eng_done is then ignored.
- Undefined: no counter; eng_abort is tied to 0; WAIT lasts indefinitely.

Test Plan:
- Requester 1 sends 503/14; engine model returns 13 after 40 cycles -> eng_start 1 cycle after req_ready[1]; rsp_valid the cycle after eng_done; rsp_id = 1, remainder = 13, divisible = 0, err = 0.
- Requester 2 sends 504/14; engine returns 0 -> rsp_divisible = 1, rsp_remainder = 0.
- All 4 requesters held valid -> grant order 0, 1, 2, 3, 0; each req_ready pulses exactly once per job.
- Requester 3 sends divisor 0, dividend 77 -> no eng_start; rsp_valid 1 cycle after grant; err = 1, remainder = 77.
- rsp_ready held low 10 cycles, then high -> rsp_* stable throughout; no new grant until the cycle after the handshake. Stray eng_done pulse in IDLE -> no response.
- rst_n dropped in WAIT -> outputs 0 asynchronously; after release, requester 0 is granted first. With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16, engine silent -> eng_abort at cycle 16 of WAIT, err = 1, remainder = 0.
